bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_controller.sv | 132 +++++++++++++
 tb/tb_bist_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// ---------------------------------------------------------------------------
// bist_controller
//
// Runs one built-in self-test session per start request. It steps a pattern
// counter through N_PATTERNS values and folds the single-bit response of the
// circuit under test into a 4-bit signature register. It then compares the
// signature against GOLDEN and holds the verdict until the next start or rst.
//
// Optional feature: define BIST_ABORT_EN to add an 'abort' input. When abort
// is high in INIT, RUN or COMPARE, the active session is dropped and the FSM
// returns to IDLE without a result.
// ---------------------------------------------------------------------------
module bist_controller #(
   parameter int         PAT_W      = 4,
   parameter int         N_PATTERNS = 16,
   parameter logic [3:0] GOLDEN     = 4'h9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef BIST_ABORT_EN
   input  logic             abort,
`endif
   input  logic             dut_resp,
   output logic [PAT_W-1:0] pattern,
   output logic             pattern_valid,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       signature
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_RUN     = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(N_PATTERNS - 1);
   localparam logic [3:0]       SIG_SEED = 4'b0001;

   state_t           r_state;
   logic [PAT_W-1:0] r_cnt;
   logic [3:0]       r_sig;
   logic             r_pattern_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   logic             w_last;
   logic             w_abort;

   assign w_last = (r_cnt == LAST_PAT);

`ifdef BIST_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Session FSM with registered status outputs; the counter is parked at 0
   // outside RUN so it can drive the pattern port directly.
   always_ff @(posedge clk) begin
      // NOTE: every state register uses non-blocking assignment so all of
      // them update together from the values that held before the edge.
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_sig           <= SIG_SEED;
         r_pattern_valid <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
      end else if (w_abort && r_busy) begin
         // An abort drops the session without a result. r_busy is high only
         // in INIT, RUN and COMPARE.
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_pattern_valid <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_INIT;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            S_INIT: begin
               r_cnt           <= '0;
               r_sig           <= SIG_SEED;
               r_pattern_valid <= 1'b1;
               r_state         <= S_RUN;
            end
            S_RUN: begin
               r_sig <= {r_sig[2:0], r_sig[1] ^ dut_resp};
               if (w_last) begin
                  // The last pattern has been applied. Stop instead of wrapping.
                  r_cnt           <= '0;
                  r_pattern_valid <= 1'b0;
                  r_state         <= S_COMPARE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_COMPARE: begin
               r_pass  <= (r_sig == GOLDEN);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign pattern       = r_cnt;
   assign pattern_valid = r_pattern_valid;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign signature     = r_sig;

endmodule

// File: tb/tb_bist_controller.sv
// ---------------------------------------------------------------------------
// tb_bist_controller
//
// Directed bench for bist_controller at its default parameters. A table of
// response models runs complete sessions that are checked against
// hand-computed signatures. Hand-written sequences then cover reset, start
// during RUN, restart from DONE, mid-RUN reset and, when BIST_ABORT_EN is
// defined, abort.
// ---------------------------------------------------------------------------
module tb_bist_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic       dut_resp;
   logic [3:0] pattern;
   logic       pattern_valid;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] signature;
`ifdef BIST_ABORT_EN
   logic       abort;
`endif

   // Response model select: 0 stuck-at-0, 1 stuck-at-1,
   // 2 loopback of pattern[3], 3 inverted loopback of pattern[3].
   logic [1:0] resp_sel;

   int checks;
   int failures;

   bist_controller dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
`ifdef BIST_ABORT_EN
      .abort         (abort),
`endif
      .dut_resp      (dut_resp),
      .pattern       (pattern),
      .pattern_valid (pattern_valid),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .signature     (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Circuit-under-test model: its response is combinational in the pattern.
   always_comb begin
      dut_resp = 1'b0;
      case (resp_sel)
         2'd0: dut_resp = 1'b0;
         2'd1: dut_resp = 1'b1;
         2'd2: dut_resp = pattern[3];
         2'd3: dut_resp = ~pattern[3];
         default: dut_resp = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Move to 1 time unit after the next rising edge. Outputs are stable then,
   // and new inputs can be set for the following edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Session table: response model and its hand-computed final signature.
   typedef struct {
      logic [1:0] sel;
      logic [3:0] exp_sig;
      logic       exp_pass;
   } vec_t;

   vec_t vecs[4];

   // Run one full session from IDLE or DONE. The start pulse is taken at
   // edge k, and done must rise exactly at edge k+18.
   task automatic run_session(input logic [1:0] sel, input logic [3:0] exp_sig,
                              input logic exp_pass);
      resp_sel = sel;
      start    = 1'b1;
      step();                                  // edge k: enter INIT
      start    = 1'b0;
      check("init_busy",  busy, 1);
      check("init_pv",    pattern_valid, 0);
      check("init_done",  done, 0);
      check("init_pass",  pass, 0);
      for (int i = 0; i < 16; i++) begin       // edges k+1..k+16: RUN
         step();
         check("run_pv",      pattern_valid, 1);
         check("run_pattern", pattern, i);
      end
      step();                                  // edge k+17: COMPARE
      check("cmp_done", done, 0);
      check("cmp_busy", busy, 1);
      check("cmp_pv",   pattern_valid, 0);
      step();                                  // edge k+18: DONE
      check("done_flag", done, 1);
      check("done_busy", busy, 0);
      check("done_pass", pass, exp_pass);
      check("done_sig",  signature, exp_sig);
      check("done_pat",  pattern, 0);
   endtask

   initial begin
      int done_seen;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start    = 1'b0;
      resp_sel = 2'd0;
`ifdef BIST_ABORT_EN
      abort    = 1'b0;
`endif

      // Sessions derived by hand from sig <= {sig[2:0], sig[1]^resp}:
      //   stuck-0 alternates 0010/0101/1010... and ends at 5.
      //   stuck-1 cycles 3,6,C,9 with period 4 and aliases onto GOLDEN 9.
      //   loopback: 8 zeros give 5, then 8 ones give 9.
      //   inverted loopback: 8 ones give 9, then 8 zeros give 5.
      vecs[0] = '{sel: 2'd2, exp_sig: 4'h9, exp_pass: 1'b1};
      vecs[1] = '{sel: 2'd0, exp_sig: 4'h5, exp_pass: 1'b0};
      vecs[2] = '{sel: 2'd1, exp_sig: 4'h9, exp_pass: 1'b1};
      vecs[3] = '{sel: 2'd3, exp_sig: 4'h5, exp_pass: 1'b0};

      // Reset held for two edges.
      repeat (2) step();
      check("rst_sig",  signature, 4'b0001);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_pat",  pattern, 0);
      check("rst_pv",   pattern_valid, 0);
      check("rst_pass", pass, 0);
      rst = 1'b0;

      // IDLE holds while start is low.
      repeat (3) step();
      check("idle_hold_busy", busy, 0);

      for (int v = 0; v < 4; v++)
         run_session(vecs[v].sel, vecs[v].exp_sig, vecs[v].exp_pass);

      // DONE holds its result while start stays low.
      repeat (4) step();
      check("hold_done", done, 1);
      check("hold_pass", pass, 0);
      check("hold_sig",  signature, 4'h5);

      // Start pulsed during RUN is ignored, and completion timing is unchanged.
      resp_sel = 2'd2;
      start    = 1'b1;
      step();                                  // edge k: INIT
      start    = 1'b0;
      repeat (5) step();                       // edges k+1..k+5
      check("midrun_pat4", pattern, 4);
      start = 1'b1;
      step();                                  // edge k+6: start must be ignored
      start = 1'b0;
      check("midrun_pat5",  pattern, 5);
      check("midrun_busy",  busy, 1);
      repeat (11) step();                      // edge k+17: COMPARE
      check("midrun_cmp_done", done, 0);
      step();                                  // edge k+18
      check("midrun_done", done, 1);
      check("midrun_pass", pass, 1);
      check("midrun_sig",  signature, 4'h9);

      // Start from DONE: done and pass drop on entering INIT.
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_done", done, 0);
      check("restart_pass", pass, 0);
      check("restart_busy", busy, 1);

      // Reset during the 5th RUN cycle discards the session.
      repeat (5) step();
      check("rst_run_pat4", pattern, 4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_run_busy", busy, 0);
      check("rst_run_sig",  signature, 4'b0001);
      check("rst_run_pat",  pattern, 0);
      check("rst_run_pv",   pattern_valid, 0);
      done_seen = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (done || busy) done_seen++;
      end
      check("rst_run_no_done", done_seen, 0);

`ifdef BIST_ABORT_EN
      // Abort in RUN returns to IDLE with no result.
      resp_sel = 2'd2;
      start    = 1'b1;
      step();
      start    = 1'b0;
      repeat (3) step();
      check("abort_in_run", pattern_valid, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_pass", pass, 0);
      check("abort_pv",   pattern_valid, 0);
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);

      // Abort in DONE is ignored.
      run_session(2'd2, 4'h9, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_done_hold_done", done, 1);
      check("abort_done_hold_pass", pass, 1);
      check("abort_done_hold_sig",  signature, 4'h9);

      // rst has priority over a simultaneous abort.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst   = 1'b1;
      abort = 1'b1;
      step();
      rst   = 1'b0;
      abort = 1'b0;
      check("rst_over_abort_sig",  signature, 4'b0001);
      check("rst_over_abort_busy", busy, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
